// File: rtl/bert_pkg.sv
// Constants shared by the BERT pattern generator and checker: pattern-select
// encodings, the PN order/tap table and the LFSR seed.
package bert_pkg;

  typedef enum logic [2:0] {
    SEL_PN7   = 3'd0,
    SEL_PN9   = 3'd1,
    SEL_PN11  = 3'd2,
    SEL_PN15  = 3'd3,
    SEL_PN23  = 3'd4,
    SEL_ZEROS = 3'd5,
    SEL_ALT   = 3'd6,
    SEL_USER  = 3'd7
  } pn_sel_e;

  localparam int                LFSR_W    = 23;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  typedef struct packed {
    logic [4:0] order;
    logic [4:0] tap;
  } pn_taps_t;

  // Non-PN selects fall back to the PN23 entry; the LFSR output is unused there.
  function automatic pn_taps_t pn_taps(input logic [2:0] sel);
    pn_taps_t r;
    case (sel)
      SEL_PN7:  r = '{order: 5'd7,  tap: 5'd6};
      SEL_PN9:  r = '{order: 5'd9,  tap: 5'd5};
      SEL_PN11: r = '{order: 5'd11, tap: 5'd9};
      SEL_PN15: r = '{order: 5'd15, tap: 5'd14};
      default:  r = '{order: 5'd23, tap: 5'd18};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bert_lfsr.sv
// Fibonacci PN generator of selectable order; o_bit is the bit emitted on the
// current advance, already accounting for lockup or mode-change reseeding.
module bert_lfsr
  import bert_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_advance,
  input  logic       i_reseed,
  input  logic [2:0] i_sel,
  output logic       o_bit
);

  logic [LFSR_W-1:0] r_s;
  logic [2:0]        r_prev_sel;

  pn_taps_t          w_taps;
  logic [LFSR_W-1:0] w_mask;
  logic [LFSR_W-1:0] w_cur;
  logic              w_seed;
  logic              w_fb;

  assign w_taps = pn_taps(i_sel);
  assign w_mask = LFSR_W'((32'd1 << w_taps.order) - 32'd1);
  // Seeding and stepping happen in the same enable, so the seed's first bit is emitted at once
  assign w_seed = ((r_s & w_mask) == '0) || (i_sel != r_prev_sel);
  assign w_cur  = w_seed ? LFSR_SEED : r_s;
  assign o_bit  = w_cur[w_taps.order - 5'd1];
  assign w_fb   = w_cur[w_taps.order - 5'd1] ^ w_cur[w_taps.tap - 5'd1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s        <= LFSR_SEED;
      r_prev_sel <= '0;
    end else if (i_reseed) begin
      r_s <= LFSR_SEED;
    end else if (i_advance) begin
      r_s        <= {w_cur[LFSR_W-2:0], w_fb};
      r_prev_sel <= i_sel;
    end
  end

endmodule

// File: rtl/bert_output_gen.sv
// BERT pattern source: PN/fixed/user pattern, optional inversion, manual and
// periodic error insertion, and a regenerated bit clock centred on each bit.
module bert_output_gen
  import bert_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [2:0]  pn_sel,
  input  logic [31:0] user_pattern,
  input  logic        invert,
  input  logic        inject_err,
  input  logic [15:0] err_rate,
  input  logic        restart,
  output logic        dout,
  output logic        dout_clk,
  output logic        dout_valid,
  output logic [15:0] err_count
);

  logic        w_step;
  logic        w_pn_bit;
  logic        w_pat_bit;
  logic        w_rate_chg;
  logic [15:0] w_cnt_eff;
  logic        w_auto_err;
  logic        w_err;

  logic [4:0]  r_idx;
  logic        r_pending;
  logic [15:0] r_bit_cnt;
  logic [15:0] r_prev_rate;
  logic        r_dout;
  logic        r_dout_clk;
  logic        r_dout_valid;
  logic [15:0] r_err_count;
  logic [15:0] r_cyc;
  logic [15:0] r_period;
  logic        r_seen_bit;

  // Restart wins over enable: no bit is emitted and the period measurement is untouched
  assign w_step = enable && !restart;

  bert_lfsr u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_advance (w_step),
    .i_reseed  (restart),
    .i_sel     (pn_sel),
    .o_bit     (w_pn_bit)
  );

  always_comb begin
    case (pn_sel)
      SEL_ZEROS: w_pat_bit = 1'b0;
      SEL_ALT:   w_pat_bit = ~r_idx[0];
      SEL_USER:  w_pat_bit = user_pattern[~r_idx];
      default:   w_pat_bit = w_pn_bit;
    endcase
  end

  assign w_rate_chg = (err_rate != r_prev_rate);
  assign w_cnt_eff  = w_rate_chg ? '0 : r_bit_cnt;
  assign w_auto_err = (err_rate != '0) && (w_cnt_eff == err_rate - 16'd1);
  // A request arriving in the enable cycle itself applies to that bit
  assign w_err      = r_pending || inject_err || w_auto_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_bit_cnt    <= '0;
      r_prev_rate  <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_prev_rate  <= err_rate;
      r_dout_valid <= w_step;
      if (restart) begin
        r_idx       <= '0;
        r_pending   <= 1'b0;
        r_bit_cnt   <= '0;
        r_err_count <= '0;
      end else if (enable) begin
        r_idx     <= r_idx + 5'd1;
        r_pending <= 1'b0;
        r_bit_cnt <= (err_rate == '0 || w_auto_err) ? '0 : w_cnt_eff + 16'd1;
        r_dout    <= w_pat_bit ^ invert ^ w_err;
        if (w_err && r_err_count != 16'hFFFF)
          r_err_count <= r_err_count + 16'd1;
      end else begin
        if (inject_err) r_pending <= 1'b1;
        if (w_rate_chg) r_bit_cnt <= '0;
      end
    end
  end

  // r_cyc is the in-bit phase: 1 on the cycle after an enable, counting up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc      <= '0;
      r_period   <= '0;
      r_seen_bit <= 1'b0;
      r_dout_clk <= 1'b0;
    end else if (w_step) begin
      r_cyc      <= 16'd1;
      r_seen_bit <= 1'b1;
      if (r_seen_bit) r_period <= r_cyc;
      r_dout_clk <= 1'b0;
    end else begin
      if (r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;
      if (r_period >= 16'd2 && r_cyc == (r_period >> 1)) r_dout_clk <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_clk   = r_dout_clk;
  assign dout_valid = r_dout_valid;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_bert_output_gen.sv
// Self-checking bench for bert_output_gen: fixed vector table, hand-written
// corner sequences, and randomized segments against a recurrence-based model.
module tb_bert_output_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  pn_sel = 3'd0;
  logic [31:0] user_pattern = 32'h0;
  logic        invert = 1'b0;
  logic        inject_err = 1'b0;
  logic [15:0] err_rate = 16'd0;
  logic        restart = 1'b0;
  logic        dout;
  logic        dout_clk;
  logic        dout_valid;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  bit pnref [0:299];

  always #5 clk = ~clk;

  bert_output_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pn_sel       (pn_sel),
    .user_pattern (user_pattern),
    .invert       (invert),
    .inject_err   (inject_err),
    .err_rate     (err_rate),
    .restart      (restart),
    .dout         (dout),
    .dout_clk     (dout_clk),
    .dout_valid   (dout_valid),
    .err_count    (err_count)
  );

  always @(negedge clk) if (dout_valid) vcount++;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] user;
    logic        inv;
    logic [31:0] exp_word;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PN output obeys o[k] = o[k-N] ^ o[k-T], starting from N ones after seeding
  task automatic build_pn(input int sel);
    int n, t;
    case (sel)
      0: begin n = 7;  t = 6;  end
      1: begin n = 9;  t = 5;  end
      2: begin n = 11; t = 9;  end
      3: begin n = 15; t = 14; end
      default: begin n = 23; t = 18; end
    endcase
    for (int k = 0; k < 300; k++) begin
      if (k < n) pnref[k] = 1'b1;
      else       pnref[k] = pnref[k-n] ^ pnref[k-t];
    end
  endtask

  function automatic bit pat_bit(input int sel, input int k, input logic [31:0] up);
    case (sel)
      5:       return 1'b0;
      6:       return (k % 2) == 0;
      7:       return up[31 - (k % 32)];
      default: return pnref[k];
    endcase
  endfunction

  task automatic send_bit(input string nm, output logic b);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check({nm, "_valid"}, dout_valid, 1'b1);
    b = dout;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_no_valid", dout_valid, 1'b0);
  endtask

  initial begin
    vec_t  vecs [8];
    logic  b;
    logic [31:0] word;

    vecs[0] = '{3'd0, 32'h0,         1'b0, 32'hFE04_1851};
    vecs[1] = '{3'd0, 32'h0,         1'b1, 32'h01FB_E7AE};
    vecs[2] = '{3'd5, 32'h0,         1'b0, 32'h0000_0000};
    vecs[3] = '{3'd5, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{3'd6, 32'h0,         1'b0, 32'hAAAA_AAAA};
    vecs[5] = '{3'd6, 32'h0,         1'b1, 32'h5555_5555};
    vecs[6] = '{3'd7, 32'hA5A5_0F0F, 1'b1, 32'h5A5A_F0F0};
    vecs[7] = '{3'd7, 32'h1234_5678, 1'b0, 32'h1234_5678};

    // Reset state
    repeat (3) tick();
    check("rst_dout", dout, 1'b0);
    check("rst_dout_clk", dout_clk, 1'b0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    reset_n = 1'b1;
    tick();

    // PN7 over a full period at one bit per 4 clk, then wrap-around
    build_pn(0);
    vcount = 0;
    for (int k = 0; k < 127; k++) begin
      send_bit("pn7", b);
      check("pn7_bit", b, pnref[k]);
      for (int c = 0; c < 3; c++) begin
        tick();
        if (k == 0) check("dclk_low_first_bit", dout_clk, 1'b0);
      end
    end
    check("pn7_valid_count", vcount, 127);
    for (int k = 127; k < 134; k++) begin
      send_bit("pn7_wrap", b);
      check("pn7_repeat", b, pnref[k-127]);
      repeat (3) tick();
    end

    // Bit clock at 10 clk per bit, then enable every clk
    for (int bi = 0; bi < 3; bi++) begin
      if (bi == 2) check("dclk_high_before_edge", dout_clk, 1'b1);
      send_bit("dclk", b);
      if (bi >= 1) check("dclk_fall", dout_clk, 1'b0);
      for (int c = 1; c <= 9; c++) begin
        tick();
        if (bi >= 1) check(c < 5 ? "dclk_low_phase" : "dclk_high_phase", dout_clk, logic'(c >= 5));
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("dclk_fast_low", dout_clk, 1'b0);
      check("fast_valid", dout_valid, 1'b1);
    end
    enable = 1'b0;
    tick();

    // Vector table: first 32 bits after restart, MSB first
    for (int v = 0; v < 8; v++) begin
      pn_sel = vecs[v].sel;
      user_pattern = vecs[v].user;
      invert = vecs[v].inv;
      err_rate = 16'd0;
      do_restart();
      word = 32'h0;
      for (int k = 0; k < 32; k++) begin
        send_bit("vec", b);
        word = {word[30:0], b};
        repeat (2) tick();
      end
      $display("vector %0d sel=%0d inv=%0d word=%h expected=%h", v, vecs[v].sel, vecs[v].inv, word, vecs[v].exp_word);
      check("vec_word", word, vecs[v].exp_word);
      check("vec_err_count", err_count, 16'd0);
    end

    // Automatic errors every 8 bits with a manual error coinciding on bit 7
    pn_sel = 3'd0;
    invert = 1'b0;
    err_rate = 16'd8;
    build_pn(0);
    do_restart();
    for (int k = 0; k < 24; k++) begin
      inject_err = (k == 7);
      send_bit("err", b);
      inject_err = 1'b0;
      check("err_bit", b, pnref[k] ^ ((k % 8) == 7));
      repeat (2) tick();
    end
    check("err_count_3", err_count, 16'd3);

    // Restart coinciding with enable
    restart = 1'b1;
    enable = 1'b1;
    tick();
    restart = 1'b0;
    enable = 1'b0;
    check("rst_en_no_valid", dout_valid, 1'b0);
    check("rst_en_err_count", err_count, 16'd0);
    repeat (2) tick();
    for (int k = 0; k < 7; k++) begin
      send_bit("after_restart", b);
      check("after_restart_bit", b, pnref[k]);
      repeat (2) tick();
    end
    err_rate = 16'd0;

    // Asynchronous reset mid-bit
    inject_err = 1'b1;
    send_bit("pre_reset", b);
    inject_err = 1'b0;
    check("pre_reset_err_count", err_count, 16'd1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_dout", dout, 1'b0);
    check("async_dout_clk", dout_clk, 1'b0);
    check("async_valid", dout_valid, 1'b0);
    check("async_err_count", err_count, 16'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      send_bit("post_reset", b);
      check("post_reset_bit", b, pnref[k]);
      repeat (3) tick();
    end
    check("post_reset_err_count", err_count, 16'd0);

    // Randomized segments against the model
    for (int seg = 0; seg < 10; seg++) begin
      int   sel, rate, ecnt;
      logic inv, pend, e, exp_b;
      logic [31:0] up;
      sel  = int'($urandom_range(7, 0));
      inv  = logic'($urandom_range(1, 0));
      rate = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(12, 2));
      up   = $urandom;
      build_pn(sel);
      pn_sel = 3'(sel);
      invert = inv;
      user_pattern = up;
      err_rate = 16'(rate);
      do_restart();
      pend = 1'b0;
      ecnt = 0;
      for (int k = 0; k < 80; k++) begin
        int gap;
        gap = int'($urandom_range(3, 0));
        for (int g = 0; g < gap; g++) begin
          inject_err = ($urandom_range(3, 0) == 0);
          if (inject_err) pend = 1'b1;
          tick();
          inject_err = 1'b0;
          check("rand_idle_valid", dout_valid, 1'b0);
        end
        inject_err = ($urandom_range(7, 0) == 0);
        if (inject_err) pend = 1'b1;
        e = pend || (rate != 0 && (k % rate) == rate - 1);
        exp_b = pat_bit(sel, k, up) ^ inv ^ e;
        send_bit("rand", b);
        inject_err = 1'b0;
        if (e) ecnt++;
        pend = 1'b0;
        check("rand_bit", b, exp_b);
      end
      $display("segment %0d sel=%0d inv=%0d rate=%0d err_count=%0d expected=%0d", seg, sel, inv, rate, err_count, ecnt);
      check("rand_err_count", err_count, 32'(ecnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bert_output_gen.md
BERT_OUTPUT_GEN -- requirements
Module: bert_output_gen

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all logic.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1: bit-rate strobe, one clk-wide pulse per output bit.
REQ-004 SHALL have port pn_sel, input, 3: pattern select; 0 PN7, 1 PN9, 2 PN11, 3 PN15, 4 PN23, 5 all-zeros, 6 alternating 1010, 7 user pattern.
REQ-005 SHALL have port user_pattern, input, 32: repeating pattern, sent MSB first.
REQ-006 SHALL have port invert, input, 1: invert every output bit.
REQ-007 SHALL have port inject_err, input, 1: single-cycle request to corrupt one bit.
REQ-008 SHALL have port err_rate, input, 16: automatic error every err_rate bits; 0 disables.
REQ-009 SHALL have port restart, input, 1: synchronous re-seed and counter clear.
REQ-010 SHALL have port dout, output, 1: serial BERT data.
REQ-011 SHALL have port dout_clk, output, 1: regenerated bit clock; falls with each new bit, rises mid-bit.
REQ-012 SHALL have port dout_valid, output, 1: one-cycle pulse marking each dout update.
REQ-013 SHALL have port err_count, output, 16: count of inserted errors, saturating.

Function
REQ-014 SHALL update dout and pulse dout_valid exactly one clk after each enable cycle.
REQ-015 SHALL implement PN modes as a 23-bit Fibonacci LFSR s; order N; output bit s[N-1]; feedback s[N-1]^s[T-1]; shift left, feedback into s[0]; advance once per enable.
REQ-016 SHALL use (N,T) = PN7 (7,6), PN9 (9,5), PN11 (11,9), PN15 (15,14), PN23 (23,18).
REQ-017 SHALL reload s with all ones at the next enable when s[N-1:0] is zero (lockup) or pn_sel has changed since the previous enable; that bit is the seeded output.
REQ-018 SHALL use a 5-bit index for mode 7, starting at 31 and decrementing mod 32 per enable; mode 6 starts with 1.
REQ-019 SHALL apply invert after pattern generation and before error insertion.
REQ-020 SHALL latch inject_err as pending until the next enable, then invert that bit and clear pending.
REQ-021 SHALL count emitted bits when err_rate != 0 and invert the bit where count reaches err_rate-1, then restart the count at 0; a change in err_rate restarts the count.
REQ-022 SHALL invert a bit only once when manual and automatic errors coincide, and increment err_count by 1.
REQ-023 SHALL saturate err_count at 16'hFFFF.
REQ-024 SHALL measure P, the number of clk cycles between consecutive enables, in a 16-bit counter that saturates at 16'hFFFF, latching P at each enable.
REQ-025 SHALL drive dout_clk low with each dout update and high when the in-bit phase counter equals P>>1.
REQ-026 SHALL hold dout_clk low while P < 2, including before the second enable.
REQ-027 SHALL give restart priority over enable: reseed s, zero indices, pending, the bit count and err_count, emit no bit, and leave P unchanged.

Reset
REQ-028 SHALL, while reset_n is low, force dout=0, dout_clk=0, dout_valid=0, err_count=0, s=all ones, P=0, pending=0, all counters 0.
REQ-029 SHALL treat the first enable after reset release as the first bit: PN output 1, or user_pattern[31] in mode 7.
REQ-030 SHALL discard partial-bit state and the P measurement when reset asserts mid-bit.

Structure
REQ-031 SHALL place the pn_sel encodings, the (N,T) tap table and the seed constant in shared package bert_pkg, for reuse by the BERT checker.
REQ-032 SHALL place the LFSR in sub-module bert_lfsr (ports: clk, reset_n, advance, reseed, order select, bit out).

Verification
REQ-033 SHALL verify: pn_sel=0, enable every 4 clk -> dout over 127 bits matches the PN7 reference, the sequence repeats at bit 128, and dout_valid count = 127.
REQ-034 SHALL verify: enable every 10 clk -> dout_clk falls 1 clk after enable and rises 5 clk later; enable every clk -> dout_clk stays 0.
REQ-035 SHALL verify: pn_sel=7, user_pattern=32'hA5A5_0F0F, invert=1 -> first 32 bits = ~A5A50F0F, MSB first.
REQ-036 SHALL verify: err_rate=8 plus inject_err coinciding with bit 7 -> bits 7,15,23 inverted once each; err_count=3.
REQ-037 SHALL verify: restart asserted in the same cycle as enable -> no dout_valid; the next enable outputs the seed bit 1; err_count=0.
REQ-038 SHALL verify: reset_n low mid-bit for 3 clk -> all outputs 0 immediately (asynchronous); after release, the sequence restarts from the seed.
